hazard_stall_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core; sits beside the EX-stage operand-forwarding unit.

---
 rtl/hazard_stall_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Hazard sequencer: load-use, taken-branch/jump flush and mul/div occupancy stalls.
// Optional perf counters enabled by defining HAZ_PERF_CNT_EN.
module hazard_stall_ctrl #(
   parameter int MD_LATENCY = 8,
   parameter int PERF_W     = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] Rs_ID,
   input  logic [4:0] Rt_ID,
   input  logic       MemRead_IDEX,
   input  logic [4:0] Write_Register_IDEX,
   input  logic       Branch_taken_EX,
   input  logic       Jump_ID,
   input  logic       MD_start_EX,
   input  logic       MD_use_ID,
   output logic       PC_Write,
   output logic       IFID_Write,
   output logic       IFID_Flush,
   output logic       IDEX_Flush,
   output logic       MD_busy
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] Stall_cycles,
   output logic [PERF_W-1:0] Flush_events
`endif
);

   typedef enum logic {RUN, MD_WAIT} state_t;

   localparam logic [7:0] MD_INIT = 8'(MD_LATENCY - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       load_use;
   logic       md_stall;

   assign load_use = MemRead_IDEX
                   & (Write_Register_IDEX != 5'd0)
                   & ((Write_Register_IDEX == Rs_ID)
                    | (Write_Register_IDEX == Rt_ID));

   assign md_stall = MD_use_ID & ((state_q == MD_WAIT) | MD_start_EX);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A start seen while already waiting is ignored; the count keeps running.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RUN: begin
            if (MD_start_EX) begin
               state_d = MD_WAIT;
               cnt_d   = MD_INIT;
            end
         end
         MD_WAIT: begin
            if (cnt_q == 8'd1) begin
               state_d = RUN;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = 8'd0;
         end
      endcase
   end

   always_comb begin
      PC_Write   = 1'b1;
      IFID_Write = 1'b1;
      IFID_Flush = 1'b0;
      IDEX_Flush = 1'b0;
      MD_busy    = MD_start_EX | (state_q == MD_WAIT);
      if (reset) begin
         PC_Write   = 1'b0;
         IFID_Write = 1'b0;
         IFID_Flush = 1'b1;
         IDEX_Flush = 1'b1;
         MD_busy    = 1'b0;
      end else if (Branch_taken_EX) begin
         IFID_Flush = 1'b1;
         IDEX_Flush = 1'b1;
      end else if (md_stall | load_use) begin
         PC_Write   = 1'b0;
         IFID_Write = 1'b0;
         IDEX_Flush = 1'b1;
      end else if (Jump_ID) begin
         IFID_Flush = 1'b1;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [PERF_W-1:0] stall_q, flush_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!PC_Write && stall_q != '1)
            stall_q <= stall_q + 1'b1;
         if (IFID_Flush && flush_q != '1)
            flush_q <= flush_q + 1'b1;
      end
   end

   assign Stall_cycles = stall_q;
   assign Flush_events = flush_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed spot checks plus random traffic
// compared every cycle against a rule-level reference model.
module tb_hazard_stall_ctrl;

   localparam int L  = 8;
   localparam int PW = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] Rs_ID, Rt_ID, Write_Register_IDEX;
   logic       MemRead_IDEX, Branch_taken_EX, Jump_ID;
   logic       MD_start_EX, MD_use_ID;
   logic       PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, MD_busy;
`ifdef HAZ_PERF_CNT_EN
   logic [PW-1:0] Stall_cycles, Flush_events;
`endif

   int checks   = 0;
   int failures = 0;

   // model state: busy cycles still to come after the current one
   int md_left = 0;
   int m_stall = 0;
   int m_flush = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.MD_LATENCY(L), .PERF_W(PW)) dut (
      .clk                 (clk),
      .reset               (reset),
      .Rs_ID               (Rs_ID),
      .Rt_ID               (Rt_ID),
      .MemRead_IDEX        (MemRead_IDEX),
      .Write_Register_IDEX (Write_Register_IDEX),
      .Branch_taken_EX     (Branch_taken_EX),
      .Jump_ID             (Jump_ID),
      .MD_start_EX         (MD_start_EX),
      .MD_use_ID           (MD_use_ID),
      .PC_Write            (PC_Write),
      .IFID_Write          (IFID_Write),
      .IFID_Flush          (IFID_Flush),
      .IDEX_Flush          (IDEX_Flush),
      .MD_busy             (MD_busy)
`ifdef HAZ_PERF_CNT_EN
      ,
      .Stall_cycles        (Stall_cycles),
      .Flush_events        (Flush_events)
`endif
   );

   // {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, MD_busy}
   function automatic logic [4:0] expect_out();
      bit waiting, lu, ms, busy;
      waiting = (md_left > 0);
      busy    = MD_start_EX || waiting;
      lu = MemRead_IDEX && Write_Register_IDEX != 0 &&
           (Write_Register_IDEX == Rs_ID ||
            Write_Register_IDEX == Rt_ID);
      ms = MD_use_ID && busy;
      if (reset)                return 5'b00110;
      else if (Branch_taken_EX) return {4'b1111, busy};
      else if (ms || lu)        return {4'b0001, busy};
      else if (Jump_ID)         return {4'b1110, busy};
      else                      return {4'b1100, busy};
   endfunction

   always @(posedge clk) begin
      logic [4:0] e;
      e = expect_out();
      if (reset) begin
         md_left = 0;
         m_stall = 0;
         m_flush = 0;
      end else begin
         if (!e[4] && m_stall < (1 << PW) - 1) m_stall++;
         if (e[2] && m_flush < (1 << PW) - 1)  m_flush++;
         if (md_left > 0)       md_left--;
         else if (MD_start_EX)  md_left = L - 1;
      end
   end

   always @(negedge clk) begin
      logic [4:0] e, g;
      e = expect_out();
      g = {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, MD_busy};
      checks++;
      if (g !== e) begin
         failures++;
         $display("FAIL cycle_outputs t=%0t got=%b exp=%b", $time, g, e);
      end
`ifdef HAZ_PERF_CNT_EN
      checks++;
      if (Stall_cycles !== PW'(m_stall) ||
          Flush_events !== PW'(m_flush)) begin
         failures++;
         $display("FAIL perf_cnt t=%0t got=%0d/%0d exp=%0d/%0d", $time,
                  Stall_cycles, Flush_events, m_stall, m_flush);
      end
`endif
   end

   task automatic clr();
      reset               = 1'b0;
      Rs_ID               = 5'd0;
      Rt_ID               = 5'd0;
      Write_Register_IDEX = 5'd0;
      MemRead_IDEX        = 1'b0;
      Branch_taken_EX     = 1'b0;
      Jump_ID             = 1'b0;
      MD_start_EX         = 1'b0;
      MD_use_ID           = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // literal check of {PC_Write,IFID_Write,IFID_Flush,IDEX_Flush} and MD_busy
   task automatic lit(input string name, input logic [3:0] ev,
                      input logic eb);
      logic [3:0] gv;
      #2;
      gv = {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush};
      checks++;
      if (gv !== ev || MD_busy !== eb) begin
         failures++;
         $display("FAIL %s got=%b/%b exp=%b/%b", name, gv, MD_busy, ev, eb);
      end
   endtask

   initial begin
      clr();
      reset = 1'b1;
      tick(); lit("reset", 4'b0011, 1'b0);

      // load-use on rs
      tick(); clr(); MemRead_IDEX = 1; Write_Register_IDEX = 8; Rs_ID = 8;
      lit("load_use", 4'b0001, 1'b0);
      tick(); clr(); lit("after_load", 4'b1100, 1'b0);

      // $0 and non-matching destinations
      tick(); clr(); MemRead_IDEX = 1;
      lit("load_r0", 4'b1100, 1'b0);
      tick(); clr(); MemRead_IDEX = 1; Write_Register_IDEX = 9;
      Rs_ID = 8; Rt_ID = 10;
      lit("load_nomatch", 4'b1100, 1'b0);

      // mul/div occupancy
      tick(); clr(); MD_start_EX = 1; lit("md_issue", 4'b1100, 1'b1);
      for (int k = 1; k <= L; k++) begin
         tick(); clr(); MD_use_ID = 1;
         if (k < L) lit($sformatf("md_wait%0d", k), 4'b0001, 1'b1);
         else       lit("md_release", 4'b1100, 1'b0);
      end

      // branch beats load-use and jump
      tick(); clr(); Branch_taken_EX = 1; Jump_ID = 1;
      MemRead_IDEX = 1; Write_Register_IDEX = 8; Rs_ID = 8;
      lit("branch_wins", 4'b1111, 1'b0);

      tick(); clr(); Jump_ID = 1; lit("jump", 4'b1110, 1'b0);
      tick(); clr(); Jump_ID = 1;
      MemRead_IDEX = 1; Write_Register_IDEX = 5; Rt_ID = 5;
      lit("jump_load_use", 4'b0001, 1'b0);

      // reset in the middle of a mul/div wait
      tick(); clr(); MD_start_EX = 1;
      tick(); clr();
      tick(); clr(); lit("md_mid", 4'b1100, 1'b1);
      tick(); clr(); reset = 1; lit("md_reset", 4'b0011, 1'b0);
      tick(); clr(); lit("md_abandoned", 4'b1100, 1'b0);

      // random traffic checked by the per-cycle compare process
      for (int n = 0; n < 3000; n++) begin
         tick();
         clr();
         reset               = ($urandom_range(0, 59) == 0);
         Rs_ID               = 5'($urandom_range(0, 3));
         Rt_ID               = 5'($urandom_range(0, 3));
         Write_Register_IDEX = 5'($urandom_range(0, 3));
         MemRead_IDEX        = ($urandom_range(0, 2) == 0);
         Branch_taken_EX     = ($urandom_range(0, 7) == 0);
         Jump_ID             = ($urandom_range(0, 5) == 0);
         MD_use_ID           = ($urandom_range(0, 2) == 0);
         if (md_left == 0)
            MD_start_EX = ($urandom_range(0, 9) == 0);
         else
            MD_start_EX = ($urandom_range(0, 99) == 0);
      end

      tick(); clr();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
